// File: rtl/uart_pkg.sv
// uart_pkg: receiver FSM state encoding and the MMIO addresses shared by the UART transmitter and receiver.
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    localparam logic [15:0] UART_DATA_ADDR   = 16'hf001;
    localparam logic [15:0] UART_STATUS_ADDR = 16'hf002;
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: circular byte FIFO for the UART receiver; a push is accepted on a full FIFO only if a pop frees a slot the same cycle.
module uart_rx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       empty,
    output logic       full
);
    localparam int AW = $clog2(DEPTH);
    logic [7:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0] r_count;
    logic w_wr, w_rd;
    assign w_wr  = push && (!full || pop);
    assign w_rd  = pop && !empty;
    assign empty = r_count == '0;
    assign full  = r_count == (AW+1)'(DEPTH);
    assign rdata = r_mem[r_rp];
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) r_wp <= r_wp + 1'b1;
            if (w_rd) r_rp <= r_rp + 1'b1;
            r_count <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_rd);
        end
    end
    // When full, push+pop writes into the slot being popped; the popped byte is read before the write lands.
    always_ff @(posedge clock) begin
        if (w_wr) r_mem[r_wp] <= wdata;
    end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling and MMIO data/status reads.
// Define UART_RX_FIFO_EN to buffer bytes in a FIFO_DEPTH FIFO instead of a single holding register.
module uart_rx
    import uart_pkg::*;
#(
    parameter int          DELAY_FRAMES = 234,
    parameter logic [15:0] DATA_ADDR    = UART_DATA_ADDR,
    parameter logic [15:0] STATUS_ADDR  = UART_STATUS_ADDR
`ifdef UART_RX_FIFO_EN
    , parameter int        FIFO_DEPTH   = 4
`endif
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        rx,
    input  logic [15:0] mmio_addr,
    input  logic        mmio_rd,
    output logic [7:0]  rd_data,
    output logic        rx_valid,
    output logic        overrun,
    output logic        frame_err
);
    localparam int CW = $clog2(DELAY_FRAMES);
    localparam logic [CW-1:0] LAST = CW'(DELAY_FRAMES - 1);
    localparam logic [CW-1:0] MID  = CW'(DELAY_FRAMES / 2 - 1);
    logic          r_rx_meta, r_rx_s;
    rx_state_t     r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          w_tick, w_push, w_stop_bad, w_ovr_set;
    logic          w_rd_data, w_rd_status, w_pop, w_empty, w_full;
    logic [7:0]    w_head, w_status;
    assign w_tick      = r_cnt == ((r_state == START) ? MID : LAST);
    assign w_push      = (r_state == STOP) && w_tick && r_rx_s;
    assign w_stop_bad  = (r_state == STOP) && w_tick && !r_rx_s;
    assign w_rd_data   = mmio_rd && (mmio_addr == DATA_ADDR);
    assign w_rd_status = mmio_rd && (mmio_addr == STATUS_ADDR);
    assign w_pop       = w_rd_data && !w_empty;
    assign w_ovr_set   = w_push && w_full && !w_pop;
    assign w_status    = {5'b0, frame_err, overrun, rx_valid};
    assign rx_valid    = !w_empty;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end
    // cnt is held at zero in IDLE, so every state is entered with a fresh count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_cnt <= (r_state == IDLE || w_tick) ? '0 : r_cnt + 1'b1;
            case (r_state)
                IDLE:  if (!r_rx_s) r_state <= START;
                START: if (w_tick) begin
                    r_state <= r_rx_s ? IDLE : DATA;
                    r_bit   <= '0;
                end
                DATA:  if (w_tick) begin
                    r_shift[r_bit] <= r_rx_s;
                    r_bit          <= r_bit + 1'b1;
                    if (r_bit == 3'd7) r_state <= STOP;
                end
                STOP:  if (w_tick) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
    // Sticky flags: a set in the same cycle as a status-read clear wins.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_data   <= '0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (mmio_rd) rd_data <= w_pop ? w_head : w_rd_status ? w_status : 8'h00;
            overrun   <= w_ovr_set || (overrun && !w_rd_status);
            frame_err <= w_stop_bad || (frame_err && !w_rd_status);
        end
    end
`ifdef UART_RX_FIFO_EN
    uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (w_push),
        .pop     (w_pop),
        .wdata   (r_shift),
        .rdata   (w_head),
        .empty   (w_empty),
        .full    (w_full)
    );
`else
    logic       r_hold_valid;
    logic [7:0] r_hold;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
        end else if (w_push && (!r_hold_valid || w_pop)) begin
            r_hold       <= r_shift;
            r_hold_valid <= 1'b1;
        end else if (w_pop) begin
            r_hold_valid <= 1'b0;
        end
    end
    assign w_head  = r_hold;
    assign w_empty = !r_hold_valid;
    assign w_full  = r_hold_valid;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at 8 clocks per bit; honours UART_RX_FIFO_EN for buffer-depth cases.
module tb_uart_rx;
    import uart_pkg::*;
    localparam int DF = 8;
`ifdef UART_RX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx = 1'b1;
    logic        mmio_rd = 1'b0;
    logic [15:0] mmio_addr = '0;
    logic [7:0]  rd_data;
    logic        rx_valid, overrun, frame_err;
    int          n_checks = 0;
    int          n_fail = 0;
    logic        v_pre, v_post;
    logic [7:0]  cap, d;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp_status;
        logic [7:0] exp_rd;
    } vec_t;
    vec_t tbl [5];

    always #5 clock = ~clock;

    uart_rx #(.DELAY_FRAMES(DF)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .rx        (rx),
        .mmio_addr (mmio_addr),
        .mmio_rd   (mmio_rd),
        .rd_data   (rd_data),
        .rx_valid  (rx_valid),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Frame bit j is driven for DF negedges; push lands on the posedge after negedge 10*DF-2.
    task automatic send(input logic [7:0] b, input logic stop, input int rd_at, input int abort_at);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int k = 0; k < 10 * DF; k++) begin
            @(negedge clock);
            if (k == abort_at) return;
            if (k == 10 * DF - 2) v_pre = rx_valid;
            if (k == 10 * DF - 1) begin
                v_post = rx_valid;
                cap    = rd_data;
            end
            rx        = f[k / DF];
            mmio_addr = UART_DATA_ADDR;
            mmio_rd   = (k == rd_at);
        end
    endtask

    task automatic rd(input logic [15:0] a, output logic [7:0] q);
        @(negedge clock);
        mmio_addr = a;
        mmio_rd   = 1'b1;
        @(negedge clock);
        mmio_rd = 1'b0;
        q = rd_data;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clock);
    endtask

    initial begin
        tbl[0] = '{8'h41, 1'b1, 8'h01, 8'h41};
        tbl[1] = '{8'h00, 1'b1, 8'h01, 8'h00};
        tbl[2] = '{8'hFF, 1'b1, 8'h01, 8'hFF};
        tbl[3] = '{8'h80, 1'b1, 8'h01, 8'h80};
        tbl[4] = '{8'h55, 1'b0, 8'h04, 8'h00};

        repeat (3) @(negedge clock);
        check("reset rd_data", rd_data, 8'h00);
        check("reset rx_valid", rx_valid, 8'h00);
        check("reset overrun", overrun, 8'h00);
        check("reset frame_err", frame_err, 8'h00);
        reset_n = 1'b1;
        idle(5);

        for (int i = 0; i < 5; i++) begin
            send(tbl[i].data, tbl[i].stop, -1, -1);
            rx = 1'b1;
            check($sformatf("vec%0d valid before mid-stop", i), v_pre, 8'h00);
            check($sformatf("vec%0d valid after mid-stop", i), v_post, 8'(tbl[i].stop));
            check($sformatf("vec%0d frame_err", i), frame_err, 8'(tbl[i].exp_status[2]));
            rd(UART_STATUS_ADDR, d);
            check($sformatf("vec%0d status", i), d, tbl[i].exp_status);
            rd(UART_STATUS_ADDR, d);
            check($sformatf("vec%0d status after clear", i), d, {7'b0, tbl[i].stop});
            rd(UART_DATA_ADDR, d);
            check($sformatf("vec%0d data", i), d, tbl[i].exp_rd);
            check($sformatf("vec%0d valid after pop", i), rx_valid, 8'h00);
            idle(20);
        end

        rx = 1'b0;
        repeat (2) @(negedge clock);
        idle(30);
        check("glitch rx_valid", rx_valid, 8'h00);
        check("glitch frame_err", frame_err, 8'h00);
        rd(UART_STATUS_ADDR, d);
        check("glitch status", d, 8'h00);

`ifdef UART_RX_FIFO_EN
        for (int i = 1; i <= 5; i++) send(8'(i), 1'b1, -1, -1);
        check("overrun flag", overrun, 8'h01);
        for (int i = 1; i <= 4; i++) begin
            rd(UART_DATA_ADDR, d);
            check($sformatf("fifo read %0d", i), d, 8'(i));
        end
`else
        send(8'h11, 1'b1, -1, -1);
        send(8'h22, 1'b1, -1, -1);
        check("overrun flag", overrun, 8'h01);
        rd(UART_DATA_ADDR, d);
        check("overrun kept byte", d, 8'h11);
`endif
        check("overrun drained", rx_valid, 8'h00);
        rd(UART_STATUS_ADDR, d);
        check("overrun status", d, 8'h02);
        check("overrun cleared", overrun, 8'h00);
        idle(5);

        for (int i = 1; i <= DEPTH; i++) send(8'hA0 + 8'(i), 1'b1, -1, -1);
        send(8'h77, 1'b1, 10 * DF - 2, -1);
        check("push+pop old byte", cap, 8'hA1);
        check("push+pop overrun", overrun, 8'h00);
        check("push+pop valid", v_post, 8'h01);
        for (int i = 2; i <= DEPTH; i++) begin
            rd(UART_DATA_ADDR, d);
            check($sformatf("push+pop drain %0d", i), d, 8'hA0 + 8'(i));
        end
        rd(UART_DATA_ADDR, d);
        check("push+pop new byte", d, 8'h77);
        check("push+pop empty", rx_valid, 8'h00);
        rd(UART_DATA_ADDR, d);
        check("empty data read", d, 8'h00);
        idle(5);

        send(8'hA5, 1'b1, -1, 5 * DF);
        reset_n = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clock);
        check("mid-frame reset rd_data", rd_data, 8'h00);
        check("mid-frame reset valid", rx_valid, 8'h00);
        reset_n = 1'b1;
        idle(5);
        send(8'h3C, 1'b1, -1, -1);
        check("post-reset valid", v_post, 8'h01);
        check("post-reset overrun", overrun, 8'h00);
        check("post-reset frame_err", frame_err, 8'h00);
        rd(16'h1234, d);
        check("other address", d, 8'h00);
        check("other address keeps byte", rx_valid, 8'h01);
        rd(UART_DATA_ADDR, d);
        check("post-reset data", d, 8'h3C);
        check("post-reset drained", rx_valid, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
